// File: rtl/scale_addr_gen_if.sv
// Address stream from the scale address generator to the pixel datapath.
// Latency: none (wires only).
// Backpressure: ADDR_READY from the consumer; producer holds the beat while low.
// Signals: ADDR_VALID/ADDR_READY handshake, RD_ADDR source address,
//          WR_ADDR output pixel index, GROUP_FIRST/GROUP_LAST group markers.
interface scale_addr_gen_if #(
   parameter int RD_AW = 15,
   parameter int WR_AW = 21
);
   logic             ADDR_VALID;
   logic             ADDR_READY;
   logic [RD_AW-1:0] RD_ADDR;
   logic [WR_AW-1:0] WR_ADDR;
   logic             GROUP_FIRST;
   logic             GROUP_LAST;

   modport master (
      output ADDR_VALID, RD_ADDR, WR_ADDR, GROUP_FIRST, GROUP_LAST,
      input  ADDR_READY
   );

   modport slave (
      input  ADDR_VALID, RD_ADDR, WR_ADDR, GROUP_FIRST, GROUP_LAST,
      output ADDR_READY
   );
endinterface

// File: rtl/scale_addr_gen.sv
// Walks one output frame, emitting source read addresses and output write indices.
// Latency: first beat the cycle after START; one beat per cycle thereafter.
// Backpressure: beat outputs hold while ADDR_READY is low; counters advance only on accept.
// Ports: CLK/RESET_N clock and async active-low reset; START + ALGORITHM/SHIFT_FACTOR/
//        IMG_WIDTH_OUT/IMG_HEIGHT_OUT frame configuration; addr address stream (master);
//        BUSY high during the walk; DONE one-cycle pulse at frame end.
module scale_addr_gen #(
   parameter int SRC_W = 160,
   parameter int SRC_H = 120,
   parameter int RD_AW = 15,
   parameter int WR_AW = 21
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  START,
   input  logic [1:0]            ALGORITHM,
   input  logic [1:0]            SHIFT_FACTOR,
   input  logic [10:0]           IMG_WIDTH_OUT,
   input  logic [9:0]            IMG_HEIGHT_OUT,
   scale_addr_gen_if.master      addr,
   output logic                  BUSY,
   output logic                  DONE
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

   localparam logic [13:0] SX_MAX = 14'(SRC_W - 1);
   localparam logic [13:0] SY_MAX = 14'(SRC_H - 1);

   state_t           r_state, w_next_state;
   logic [1:0]       r_alg, r_s;
   logic [10:0]      r_w, r_out_x;
   logic [9:0]       r_h, r_out_y;
   logic [2:0]       r_sub_x, r_sub_y;
   logic [WR_AW-1:0] r_wr_addr;
   logic             r_zero_pend;

   logic             w_valid, w_fire, w_start_ok, w_zero_cfg;
   logic [2:0]       w_sub_max;
   logic             w_sub_x_last, w_sub_y_last, w_grp_first, w_grp_last;
   logic             w_x_last, w_y_last;
   logic [13:0]      w_ox_ext, w_oy_ext, w_sx_raw, w_sy_raw;
   logic [RD_AW-1:0] w_sx_c, w_sy_c, w_rd;

   assign w_valid    = (r_state == S_RUN);
   assign w_fire     = w_valid & addr.ADDR_READY;
   assign w_zero_cfg = (IMG_WIDTH_OUT == 11'd0) || (IMG_HEIGHT_OUT == 10'd0);
   // A pending empty frame still occupies IDLE for one cycle, so START is not accepted then.
   assign w_start_ok = START && (r_state == S_IDLE) && !r_zero_pend;

   // Only block-average walks a sub-grid; every other mode is a 1x1 group.
   assign w_sub_max    = (r_alg == 2'b11) ? 3'((4'd1 << r_s) - 4'd1) : 3'd0;
   assign w_sub_x_last = (r_sub_x == w_sub_max);
   assign w_sub_y_last = (r_sub_y == w_sub_max);
   assign w_grp_first  = (r_sub_x == 3'd0) && (r_sub_y == 3'd0);
   assign w_grp_last   = w_sub_x_last && w_sub_y_last;
   assign w_x_last     = (r_out_x == r_w - 11'd1);
   assign w_y_last     = (r_out_y == r_h - 10'd1);

   assign w_ox_ext = {3'b000, r_out_x};
   assign w_oy_ext = {4'b0000, r_out_y};

   always_comb begin
      w_sx_raw = w_ox_ext;
      w_sy_raw = w_oy_ext;
      case (r_alg)
         2'b10: begin
            w_sx_raw = w_ox_ext << r_s;
            w_sy_raw = w_oy_ext << r_s;
         end
         2'b11: begin
            w_sx_raw = (w_ox_ext << r_s) + {11'd0, r_sub_x};
            w_sy_raw = (w_oy_ext << r_s) + {11'd0, r_sub_y};
         end
         default: begin
            w_sx_raw = w_ox_ext >> r_s;
            w_sy_raw = w_oy_ext >> r_s;
         end
      endcase
   end

   // Saturate so an oversized output frame never reads outside the source image.
   assign w_sx_c = (w_sx_raw > SX_MAX) ? RD_AW'(SX_MAX) : RD_AW'(w_sx_raw);
   assign w_sy_c = (w_sy_raw > SY_MAX) ? RD_AW'(SY_MAX) : RD_AW'(w_sy_raw);
   // y*160 as y*128 + y*32.
   assign w_rd   = (w_sy_c << 7) + (w_sy_c << 5) + w_sx_c;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) r_state <= S_IDLE;
      else          r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (r_zero_pend)                    w_next_state = S_FIN;
            else if (w_start_ok && !w_zero_cfg) w_next_state = S_RUN;
         end
         S_RUN: begin
            if (w_fire && w_grp_last && w_x_last && w_y_last) w_next_state = S_FIN;
         end
         S_FIN:   w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_alg       <= 2'd0;
         r_s         <= 2'd0;
         r_w         <= 11'd0;
         r_h         <= 10'd0;
         r_out_x     <= 11'd0;
         r_out_y     <= 10'd0;
         r_sub_x     <= 3'd0;
         r_sub_y     <= 3'd0;
         r_wr_addr   <= '0;
         r_zero_pend <= 1'b0;
      end else begin
         r_zero_pend <= 1'b0;
         if (w_start_ok) begin
            r_alg       <= ALGORITHM;
            r_s         <= SHIFT_FACTOR;
            r_w         <= IMG_WIDTH_OUT;
            r_h         <= IMG_HEIGHT_OUT;
            r_out_x     <= 11'd0;
            r_out_y     <= 10'd0;
            r_sub_x     <= 3'd0;
            r_sub_y     <= 3'd0;
            r_wr_addr   <= '0;
            r_zero_pend <= w_zero_cfg;
         end else if (w_fire) begin
            if (!w_grp_last) begin
               if (w_sub_x_last) begin
                  r_sub_x <= 3'd0;
                  r_sub_y <= r_sub_y + 3'd1;
               end else begin
                  r_sub_x <= r_sub_x + 3'd1;
               end
            end else begin
               r_sub_x   <= 3'd0;
               r_sub_y   <= 3'd0;
               r_wr_addr <= r_wr_addr + WR_AW'(1);
               if (w_x_last) begin
                  r_out_x <= 11'd0;
                  if (!w_y_last) r_out_y <= r_out_y + 10'd1;
               end else begin
                  r_out_x <= r_out_x + 11'd1;
               end
            end
         end
      end
   end

   // Beat outputs are forced to zero outside RUN so IDLE/FIN/reset present a quiet bus.
   assign addr.ADDR_VALID  = w_valid;
   assign addr.RD_ADDR     = w_valid ? w_rd : '0;
   assign addr.WR_ADDR     = w_valid ? r_wr_addr : '0;
   assign addr.GROUP_FIRST = w_valid & w_grp_first;
   assign addr.GROUP_LAST  = w_valid & w_grp_last;
   assign BUSY             = w_valid;
   assign DONE             = (r_state == S_FIN);

endmodule
